icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Two-way set-associative, read-only instruction cache controller between the CPU fetch stage and the memory read channel.
- Owns lookup, hit/miss decision, victim selection, burst refill and response sequencing.
- Instantiates per-way tag and data storage arrays, which are purely storage:
  - 8 sets.
  - Combinational read.
  - Synchronous write.
  - Cleared on reset.
- This block drives their read and write ports.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- SET_BITS, 3, log2 of set count (8 sets).
- OFFSET_BITS, 5, log2 of line bytes (32 B line = 8 words).
- TAG_BITS, ADDR_WIDTH-SET_BITS-OFFSET_BITS = 24, tag width stored per way.
- LINE_BITS, 256, data width of one line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- from_cpu_inst_req_valid  in  1  fetch request valid
- from_cpu_inst_req_addr  in  32  fetch address (word aligned)
- to_cpu_inst_req_ready  out  1  request accepted this cycle
- to_cpu_cache_rsp_valid  out  1  instruction word valid
- to_cpu_cache_rsp_data  out  32  instruction word
- from_cpu_cache_rsp_ready  in  1  CPU accepts response
- to_mem_rd_req_valid  out  1  line read request valid
- to_mem_rd_req_addr  out  32  line-aligned address (offset bits zero)
- from_mem_rd_req_ready  in  1  memory accepts request
- from_mem_rd_rsp_valid  in  1  refill beat valid
- from_mem_rd_rsp_data  in  32  refill beat data
- from_mem_rd_rsp_last  in  1  final beat of burst
- to_mem_rd_rsp_ready  out  1  controller accepts beat

Behaviour:
- Reset (rst=1 at posedge) has priority over all activity, including a request or refill in flight:
  - state=IDLE; all outputs 0.
  - valid[way][set]=0 and lru[set]=0 for all sets.
  - Beat counter=0; refill buffer contents don't-care.
  - Pending memory beats are not tracked after reset.
- States: IDLE, LOOKUP, MEM_REQ, RECV, REFILL, RESP.
- IDLE:
  - to_cpu_inst_req_ready=1.
  - On valid&ready: latch addr into req_addr and go to LOOKUP.
- LOOKUP (1 cycle):
  - Arrays read combinationally with set=req_addr[7:5].
  - hit_w = valid[w][set] & (tag_w == req_addr[31:8]).
  - Hit: select word req_addr[4:2] of the hit way's line; lru[set] <= ~hit way; go to RESP.
  - Miss: choose victim = way0 if invalid, else way1 if invalid, else lru[set]; go to MEM_REQ.
  - Both ways hitting cannot occur by construction; way0 wins if it does.
- MEM_REQ:
  - to_mem_rd_req_valid=1, addr = {req_addr[31:5], 5'b0}.
  - Go to RECV on from_mem_rd_req_ready.
  - valid and addr are held stable until accepted.
- RECV:
  - to_mem_rd_rsp_ready=1.
  - Each valid beat is written into refill buffer word[cnt], then cnt++ (3-bit).
  - A beat with last=1 ends RECV and moves to REFILL; cnt resets to 0.
  - If last arrives before 8 beats, the unwritten words are 0.
  - Beats arriving in other states are not accepted (rsp_ready=0).
- REFILL (1 cycle):
  - Tag/data write-enable for the victim way only: tag=req_addr[31:8], data=buffer.
  - valid[victim][set] <= 1; lru[set] <= ~victim.
  - Response word = buffer word[req_addr[4:2]]; go to RESP.
- RESP:
  - to_cpu_cache_rsp_valid=1 with data held stable.
  - Return to IDLE on from_cpu_cache_rsp_ready.
  - Data register holds its value after the handshake; rsp_valid falls the next cycle.
- Latency:
  - Hit: req handshake at cycle 0, rsp_valid at cycle 2.
  - Miss: 2 + mem request wait + beats + 1 cycles.
- One outstanding request; no request is accepted outside IDLE.

Decomposition:
- Shared package holds:
  - State encodings (one-hot, 6 bits).
  - Field-slice constants: TAG_LSB=8, SET_LSB=5, WORD_LSB=2.
  - Line/word widths.
- One sub-module is natural: icache_refill_buf.
  - 8x32 register file with clear, beat write port, word-select read port and full-line output.
- Valid/LRU flops and the FSM stay in icache_ctrl.

Test Plan:
- Reset, then a fetch at 0x0000_1004 with memory returning words 0xA0..0xA7 -> one mem req addr 0x0000_1000, 8 beats accepted, rsp_data=0xA1, valid[v][0]=1.
- Fetch 0x0000_1008 immediately after -> hit, no mem req, rsp_valid exactly 2 cycles after the req handshake, data 0xA2.
- Fill set 0 with tags 0x10 and 0x20, touch 0x10 again, then fetch tag 0x30 set 0 -> the way holding 0x20 is replaced; a later fetch of 0x10 hits.
- from_cpu_cache_rsp_ready held low 5 cycles in RESP -> rsp_valid/data stable all 5 cycles; req_ready=0 throughout.
- from_mem_rd_req_ready low 4 cycles, then beats with valid gaps -> addr stable; buffer assembles correctly; only valid beats increment cnt.
- rst asserted mid-RECV after 3 beats -> next cycle state IDLE, all outputs 0; a refetch of the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the two-way instruction cache: geometry, address
// field positions, FSM state encoding and a line word-select helper.
package icache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int SET_BITS    = 3;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_BITS    = ADDR_WIDTH - SET_BITS - OFFSET_BITS;
    localparam int WORD_WIDTH  = 32;
    localparam int WORD_BITS   = 3;
    localparam int LINE_WORDS  = 8;
    localparam int LINE_BITS   = 256;
    localparam int NUM_SETS    = 8;
    localparam int NUM_WAYS    = 2;

    localparam int TAG_LSB  = 8;
    localparam int SET_LSB  = 5;
    localparam int WORD_LSB = 2;

    typedef enum logic [5:0] {
        S_IDLE    = 6'b000001,
        S_LOOKUP  = 6'b000010,
        S_MEM_REQ = 6'b000100,
        S_RECV    = 6'b001000,
        S_REFILL  = 6'b010000,
        S_RESP    = 6'b100000
    } state_t;

    function automatic logic [WORD_WIDTH-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [WORD_BITS-1:0] idx
    );
        return line[idx*WORD_WIDTH +: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/icache_refill_buf.sv
// Eight-word staging buffer that assembles a refill burst before it is
// committed to the victim way; cleared on reset and before each burst.
module icache_refill_buf
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [WORD_BITS-1:0]  widx,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [WORD_BITS-1:0]  ridx,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic [LINE_BITS-1:0]  line
);

    logic [WORD_WIDTH-1:0] words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (we) begin
            words[widx] <= wdata;
        end
    end

    assign rdata = words[ridx];

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
        assign line[g*WORD_WIDTH +: WORD_WIDTH] = words[g];
    end

endmodule

// File: rtl/icache_ctrl.sv
// Two-way set-associative read-only instruction cache controller: lookup,
// victim choice, burst refill from memory and response to the fetch stage.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  from_cpu_inst_req_valid,
    input  logic [ADDR_WIDTH-1:0] from_cpu_inst_req_addr,
    output logic                  to_cpu_inst_req_ready,
    output logic                  to_cpu_cache_rsp_valid,
    output logic [WORD_WIDTH-1:0] to_cpu_cache_rsp_data,
    input  logic                  from_cpu_cache_rsp_ready,
    output logic                  to_mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] to_mem_rd_req_addr,
    input  logic                  from_mem_rd_req_ready,
    input  logic                  from_mem_rd_rsp_valid,
    input  logic [WORD_WIDTH-1:0] from_mem_rd_rsp_data,
    input  logic                  from_mem_rd_rsp_last,
    output logic                  to_mem_rd_rsp_ready
);

    // Every channel uses valid/ready: a transfer happens on a cycle where both
    // are high, and the sender holds valid and payload stable until then.

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]                  req_addr;
    logic [TAG_BITS-1:0]                    tag_mem  [NUM_WAYS][NUM_SETS];
    logic [LINE_BITS-1:0]                   data_mem [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0][NUM_SETS-1:0]      valid_q;
    logic [NUM_SETS-1:0]                    lru_q;
    logic                                   victim_q;
    logic [WORD_BITS-1:0]                   cnt_q;
    logic [WORD_WIDTH-1:0]                  rsp_data_q;

    logic [SET_BITS-1:0]   set_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [WORD_BITS-1:0]  word_idx;
    logic                  hit0, hit1, hit, hit_way, miss_victim;
    logic [WORD_WIDTH-1:0] hit_word;
    logic                  beat_we, fill_we;
    logic [WORD_WIDTH-1:0] buf_rdata;
    logic [LINE_BITS-1:0]  buf_line;
    logic                  addr_unused;

    assign set_idx     = req_addr[SET_LSB +: SET_BITS];
    assign req_tag     = req_addr[TAG_LSB +: TAG_BITS];
    assign word_idx    = req_addr[WORD_LSB +: WORD_BITS];
    assign addr_unused = ^req_addr[WORD_LSB-1:0];

    assign hit0        = valid_q[0][set_idx] && (tag_mem[0][set_idx] == req_tag);
    assign hit1        = valid_q[1][set_idx] && (tag_mem[1][set_idx] == req_tag);
    assign hit         = hit0 || hit1;
    assign hit_way     = hit0 ? 1'b0 : 1'b1;
    assign hit_word    = line_word(data_mem[hit_way][set_idx], word_idx);
    // Fill invalid ways first (way0 before way1) so LRU only decides on full sets.
    assign miss_victim = !valid_q[0][set_idx] ? 1'b0 :
                         !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];

    assign beat_we = (state == S_RECV) && from_mem_rd_rsp_valid;
    assign fill_we = (state == S_REFILL);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (from_cpu_inst_req_valid) state_nx = S_LOOKUP;
            S_LOOKUP:  state_nx = hit ? S_RESP : S_MEM_REQ;
            S_MEM_REQ: if (from_mem_rd_req_ready) state_nx = S_RECV;
            S_RECV:    if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) state_nx = S_REFILL;
            S_REFILL:  state_nx = S_RESP;
            S_RESP:    if (from_cpu_cache_rsp_ready) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // req_ready is masked while reset is held so every output reads 0 then.
    assign to_cpu_inst_req_ready  = (state == S_IDLE) && !rst;
    assign to_cpu_cache_rsp_valid = (state == S_RESP);
    assign to_cpu_cache_rsp_data  = rsp_data_q;
    assign to_mem_rd_req_valid    = (state == S_MEM_REQ);
    assign to_mem_rd_req_addr     = to_mem_rd_req_valid ?
                                    {req_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
    assign to_mem_rd_rsp_ready    = (state == S_RECV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            valid_q    <= '0;
            lru_q      <= '0;
            victim_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && from_cpu_inst_req_valid) begin
                req_addr <= from_cpu_inst_req_addr;
            end
            if (state == S_LOOKUP) begin
                if (hit) begin
                    rsp_data_q     <= hit_word;
                    lru_q[set_idx] <= ~hit_way;
                end else begin
                    victim_q <= miss_victim;
                end
            end
            if (beat_we) begin
                cnt_q <= from_mem_rd_rsp_last ? '0 : cnt_q + 1'b1;
            end
            if (fill_we) begin
                valid_q[victim_q][set_idx] <= 1'b1;
                lru_q[set_idx]             <= ~victim_q;
                rsp_data_q                 <= buf_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    tag_mem[w][s]  <= '0;
                    data_mem[w][s] <= '0;
                end
            end
        end else if (fill_we) begin
            tag_mem[victim_q][set_idx]  <= req_tag;
            data_mem[victim_q][set_idx] <= buf_line;
        end
    end

    // Cleared while the line request is outstanding so short bursts leave zeros.
    icache_refill_buf u_refill_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_MEM_REQ),
        .we    (beat_we),
        .widx  (cnt_q),
        .wdata (from_mem_rd_rsp_data),
        .ridx  (word_idx),
        .rdata (buf_rdata),
        .line  (buf_line)
    );

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: randomized fetches against a per-set
// recency-list cache model and a word-addressed memory model.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        from_cpu_inst_req_valid;
    logic [31:0] from_cpu_inst_req_addr;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready;
    logic        from_mem_rd_rsp_valid;
    logic [31:0] from_mem_rd_rsp_data;
    logic        from_mem_rd_rsp_last;
    logic        to_mem_rd_rsp_ready;

    int checks = 0;
    int errors = 0;

    // Model: per set, resident tags ordered least- to most-recently used.
    logic [23:0]  set_q [8][$];
    logic [255:0] cached [logic [31:0]];
    logic [31:0]  exp_q [$];

    always #5 clk = ~clk;

    icache_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
        logic [31:0] r;
        if (line == 32'h0000_1000) begin
            r = 32'hA0 + i;
        end else begin
            r = {line[23:0], 8'h00} ^ (32'h1111_1111 * (i + 1)) ^ 32'hC0DE_0000;
        end
        return r;
    endfunction

    task automatic clear_inputs();
        from_cpu_inst_req_valid  = 1'b0;
        from_cpu_inst_req_addr   = '0;
        from_cpu_cache_rsp_ready = 1'b0;
        from_mem_rd_req_ready    = 1'b0;
        from_mem_rd_rsp_valid    = 1'b0;
        from_mem_rd_rsp_data     = '0;
        from_mem_rd_rsp_last     = 1'b0;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) set_q[s].delete();
        cached.delete();
    endtask

    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // One complete fetch; caller is at a negedge with the DUT idle.
    task automatic fetch(input logic [31:0] addr, input int req_wait, input int gap_max,
                         input int nbeats, input int stall);
        logic [31:0]  line, got, exp_word;
        logic [2:0]   s, w;
        logic [23:0]  tg;
        logic [255:0] newline;
        bit           exp_hit, req_prev, busy_ready;
        int           pos, reqs, first_req, wait_left, sent, accept_idx, last_idx, rsp_idx;
        line = {addr[31:5], 5'b0};
        s    = addr[7:5];
        w    = addr[4:2];
        tg   = addr[31:8];
        pos  = -1;
        for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i] == tg) pos = i;
        exp_hit = (pos >= 0);
        newline = '0;
        if (exp_hit) newline = cached[line];
        else for (int i = 0; i < nbeats; i++) newline[i*32 +: 32] = mem_word(line, i);
        exp_q.push_back(newline[w*32 +: 32]);

        checks++;
        if (to_cpu_inst_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_req_ready addr=%h got=%b exp=1", addr, to_cpu_inst_req_ready);
        end
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = addr;
        reqs = 0; first_req = -1; wait_left = req_wait; sent = 0;
        accept_idx = -1; last_idx = -1; rsp_idx = -1; req_prev = 0; busy_ready = 0;
        for (int k = 1; k <= 300 && rsp_idx < 0; k++) begin
            @(negedge clk);
            from_cpu_inst_req_valid = 1'b0;
            from_mem_rd_req_ready   = 1'b0;
            from_mem_rd_rsp_valid   = 1'b0;
            from_mem_rd_rsp_last    = 1'b0;
            if (to_cpu_inst_req_ready) busy_ready = 1;
            if (to_cpu_cache_rsp_valid) begin
                rsp_idx = k;
            end else begin
                if (to_mem_rd_req_valid) begin
                    if (!req_prev) begin
                        reqs++;
                        if (first_req < 0) first_req = k;
                    end
                    checks++;
                    if (to_mem_rd_req_addr !== line) begin
                        errors++;
                        $display("FAIL mem_req_addr cycle=%0d got=%h exp=%h", k, to_mem_rd_req_addr, line);
                    end
                    if (wait_left > 0) begin
                        wait_left--;
                    end else begin
                        from_mem_rd_req_ready = 1'b1;
                        accept_idx = k;
                    end
                end
                req_prev = to_mem_rd_req_valid;
                if (to_mem_rd_rsp_ready && sent < nbeats) begin
                    if (gap_max == 0 || $urandom_range(0, gap_max) == 0) begin
                        from_mem_rd_rsp_valid = 1'b1;
                        from_mem_rd_rsp_data  = mem_word(line, sent);
                        from_mem_rd_rsp_last  = (sent == nbeats - 1);
                        if (sent == nbeats - 1) last_idx = k;
                        sent++;
                    end
                end
            end
        end
        if (rsp_idx < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout addr=%h got=no_response exp=response", addr);
            finish_now();
            return;
        end

        checks++;
        if (busy_ready) begin
            errors++;
            $display("FAIL busy_req_ready addr=%h got=1 exp=0", addr);
        end
        checks++;
        if (reqs != (exp_hit ? 0 : 1)) begin
            errors++;
            $display("FAIL mem_req_count addr=%h got=%0d exp=%0d", addr, reqs, exp_hit ? 0 : 1);
        end
        if (exp_hit) begin
            checks++;
            if (rsp_idx != 2) begin
                errors++;
                $display("FAIL hit_latency addr=%h got=%0d exp=2", addr, rsp_idx);
            end
        end else begin
            checks++;
            if (first_req != 2 || accept_idx != 2 + req_wait) begin
                errors++;
                $display("FAIL mem_req_timing addr=%h got=%0d/%0d exp=2/%0d",
                         addr, first_req, accept_idx, 2 + req_wait);
            end
            checks++;
            if (sent != nbeats || rsp_idx != last_idx + 2) begin
                errors++;
                $display("FAIL refill_timing addr=%h got=%0d beats rsp@%0d exp=%0d beats rsp@%0d",
                         addr, sent, rsp_idx, nbeats, last_idx + 2);
            end
        end
        got      = to_cpu_cache_rsp_data;
        exp_word = exp_q.pop_front();
        checks++;
        if (got !== exp_word) begin
            errors++;
            $display("FAIL rsp_data addr=%h got=%h exp=%h", addr, got, exp_word);
        end

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (to_cpu_cache_rsp_valid !== 1'b1 || to_cpu_cache_rsp_data !== got ||
                to_cpu_inst_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL rsp_stall_hold cycle=%0d got=v%b d%h r%b exp=v1 d%h r0", i,
                         to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data, to_cpu_inst_req_ready, got);
            end
        end
        from_cpu_cache_rsp_ready = 1'b1;
        @(negedge clk);
        from_cpu_cache_rsp_ready = 1'b0;
        checks++;
        if (to_cpu_cache_rsp_valid !== 1'b0 || to_cpu_inst_req_ready !== 1'b1 ||
            to_cpu_cache_rsp_data !== got) begin
            errors++;
            $display("FAIL rsp_release got=v%b r%b d%h exp=v0 r1 d%h",
                     to_cpu_cache_rsp_valid, to_cpu_inst_req_ready, to_cpu_cache_rsp_data, got);
        end

        if (exp_hit) begin
            set_q[s].delete(pos);
        end else begin
            if (set_q[s].size() == 2) begin
                cached.delete({set_q[s][0], s, 5'b0});
                void'(set_q[s].pop_front());
            end
            cached[line] = newline;
        end
        set_q[s].push_back(tg);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
                 to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle=%0d got=nonzero exp=0", i);
            end
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (to_cpu_inst_req_ready !== 1'b1 || to_cpu_cache_rsp_valid !== 1'b0 ||
            to_mem_rd_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got=r%b v%b m%b exp=r1 v0 m0",
                     to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_mem_rd_req_valid);
        end
    endtask

    task automatic test_first_miss();
        fetch(32'h0000_1004, 0, 0, 8, 0);
    endtask

    task automatic test_hit();
        fetch(32'h0000_1008, 0, 0, 8, 0);
    endtask

    task automatic test_lru();
        fetch(32'h0000_2000, 0, 0, 8, 0);
        fetch(32'h0000_1000, 0, 0, 8, 0);
        fetch(32'h0000_3010, 0, 0, 8, 0);
        fetch(32'h0000_101C, 0, 0, 8, 0);
        fetch(32'h0000_3000, 0, 0, 8, 0);
        fetch(32'h0000_2004, 0, 0, 8, 0);
    endtask

    task automatic test_rsp_stall();
        fetch(32'h0000_1010, 0, 0, 8, 5);
        fetch(32'h0000_40A8, 1, 0, 8, 5);
    endtask

    task automatic test_mem_backpressure();
        fetch(32'h0000_4004, 4, 2, 8, 0);
        fetch(32'h0000_4018, 0, 0, 8, 0);
    endtask

    task automatic test_short_burst();
        fetch(32'h0000_5024, 0, 1, 3, 0);
        fetch(32'h0000_5038, 0, 0, 8, 0);
        fetch(32'h0000_5028, 0, 0, 8, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [23:0] tags [5];
        tags[0] = 24'h10; tags[1] = 24'h20; tags[2] = 24'h30; tags[3] = 24'h45; tags[4] = 24'h7A;
        for (int n = 0; n < 40; n++) begin
            a = {tags[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 8, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_recv();
        logic [31:0] a;
        int beats;
        a = 32'h0000_6044;
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = a;
        beats = 0;
        for (int k = 0; k < 50 && beats < 3; k++) begin
            @(negedge clk);
            from_cpu_inst_req_valid = 1'b0;
            from_mem_rd_req_ready   = to_mem_rd_req_valid;
            from_mem_rd_rsp_valid   = 1'b0;
            if (to_mem_rd_rsp_ready) begin
                from_mem_rd_rsp_valid = 1'b1;
                from_mem_rd_rsp_data  = mem_word({a[31:5], 5'b0}, beats);
                from_mem_rd_rsp_last  = 1'b0;
                beats++;
            end
        end
        checks++;
        if (beats != 3) begin
            errors++;
            $display("FAIL mid_recv_beats got=%0d exp=3", beats);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
             to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready} !== '0) begin
            errors++;
            $display("FAIL mid_recv_reset_outputs got=r%b v%b m%b rr%b exp=all0", to_cpu_inst_req_ready,
                     to_cpu_cache_rsp_valid, to_mem_rd_req_valid, to_mem_rd_rsp_ready);
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        fetch(a, 0, 0, 8, 0);
        fetch(32'h0000_1004, 0, 0, 8, 0);
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hit();
        test_lru();
        test_rsp_stall();
        test_mem_backpressure();
        test_short_burst();
        test_random();
        test_reset_mid_recv();
        repeat (2) @(negedge clk);
        finish_now();
    end

endmodule
